// File: rtl/nlu_pkg.sv
// Shared types and helpers for the banked ANF S-box unit.
// Holds the load FSM states and the mask geometry of one SW-bit S-box.
package nlu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } ld_state_e;

  function automatic int anf_mask_bits(input int sw);
    return sw * (1 << sw);
  endfunction

  // Field j holds output bit j; monomial m sits at the MSB end of its field.
  function automatic int coef_idx(input int sw, input int j, input int m);
    return j * (1 << sw) + (1 << sw) - 1 - m;
  endfunction

endpackage

// File: rtl/nlu_anf_sbox.sv
// Combinational single S-box evaluated from its ANF coefficient mask.
// Zero latency; no flow control.
module nlu_anf_sbox
  import nlu_pkg::*;
#(
  parameter int SW = 4
) (
  input  logic [anf_mask_bits(SW)-1:0] mask,
  input  logic [SW-1:0]                x,
  output logic [SW-1:0]                y
);

  localparam int MB = anf_mask_bits(SW);
  localparam int IW = $clog2(MB);

  always_comb begin
    y = '0;
    for (int j = 0; j < SW; j++) begin
      for (int m = 0; m < (1 << SW); m++) begin
        // monomial m is 1 when every variable it names is 1
        if ((x & SW'(m)) == SW'(m)) begin
          y[j] = y[j] ^ mask[IW'(coef_idx(SW, j, m))];
        end
      end
    end
  end

endmodule

// File: rtl/nlu_anf_banked.sv
// Banked ANF S-box unit: shadow-loaded masks, atomic commit, one registered result stage.
// Latency 1 cycle; in_ready = !out_valid || out_ready, so a stalled result holds and blocks input.
module nlu_anf_banked
  import nlu_pkg::*;
#(
  parameter  int DW    = 32,
  parameter  int SW    = 4,
  parameter  int PW    = 16,
  parameter  int NBANK = 2,
  localparam int BW    = (NBANK > 1) ? $clog2(NBANK) : 1
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [BW-1:0]    ld_bank,
  input  logic [PW-1:0]    ld_data,
  input  logic             ld_abort,
  output logic             ld_done,
  output logic [NBANK-1:0] bank_vld,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BW-1:0]    in_bank,
  input  logic [DW-1:0]    din,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    dout,
  output logic             out_err
);

  localparam int MB    = anf_mask_bits(SW);
  localparam int NPUSH = MB / PW;
  localparam int NS    = DW / SW;
  localparam int CW    = $clog2(NPUSH + 1);

  ld_state_e         state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [MB-1:0]     shadow_q, shadow_d;
  logic [BW-1:0]     sel_q, sel_d;
  logic [MB-1:0]     banks_q [NBANK];
  logic [MB-1:0]     banks_d [NBANK];
  logic [NBANK-1:0]  bank_vld_q, bank_vld_d;
  logic              ld_done_q, ld_done_d;
  logic              out_valid_q, out_valid_d;
  logic [DW-1:0]     dout_q, dout_d;
  logic              out_err_q, out_err_d;
  logic              beat;
  logic [MB-1:0]     sel_mask;
  logic              sel_ok;
  logic [DW-1:0]     sbox_y;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shadow_d   = shadow_q;
    sel_d      = sel_q;
    banks_d    = banks_q;
    bank_vld_d = bank_vld_q;
    ld_done_d  = 1'b0;
    ld_ready   = (state_q != COMMIT);
    beat       = ld_valid && ld_ready;
    case (state_q)
      IDLE, LOAD: begin
        if (ld_abort) begin
          state_d  = IDLE;
          cnt_d    = '0;
          shadow_d = '0;
        end else if (beat) begin
          if (state_q == IDLE) sel_d = ld_bank;
          // cnt is 0 in IDLE, so beat cnt lands in word NPUSH-1-cnt (MSW first)
          for (int w = 0; w < NPUSH; w++) begin
            if (cnt_q == CW'(w)) shadow_d[(NPUSH-1-w)*PW +: PW] = ld_data;
          end
          cnt_d   = cnt_q + CW'(1);
          state_d = (cnt_q == CW'(NPUSH - 1)) ? COMMIT : LOAD;
        end
      end
      COMMIT: begin
        // out-of-range targets match no bank and so commit nothing
        for (int b = 0; b < NBANK; b++) begin
          if (sel_q == BW'(b)) begin
            banks_d[b]    = shadow_q;
            bank_vld_d[b] = 1'b1;
            ld_done_d     = 1'b1;
          end
        end
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    sel_mask = '0;
    sel_ok   = 1'b0;
    for (int b = 0; b < NBANK; b++) begin
      if (in_bank == BW'(b)) begin
        sel_mask = banks_q[b];
        sel_ok   = bank_vld_q[b];
      end
    end
  end

  for (genvar k = 0; k < NS; k++) begin : g_sbox
    nlu_anf_sbox #(.SW(SW)) u_sbox (
      .mask (sel_mask),
      .x    (din[k*SW +: SW]),
      .y    (sbox_y[k*SW +: SW])
    );
  end

  always_comb begin
    in_ready    = !out_valid_q || out_ready;
    out_valid_d = out_valid_q;
    dout_d      = dout_q;
    out_err_d   = out_err_q;
    if (in_ready) begin
      out_valid_d = in_valid;
      if (in_valid) begin
        dout_d    = sel_ok ? sbox_y : '0;
        out_err_d = !sel_ok;
      end
    end
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shadow_q    <= '0;
      sel_q       <= '0;
      bank_vld_q  <= '0;
      ld_done_q   <= 1'b0;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      out_err_q   <= 1'b0;
      for (int b = 0; b < NBANK; b++) banks_q[b] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shadow_q    <= shadow_d;
      sel_q       <= sel_d;
      bank_vld_q  <= bank_vld_d;
      ld_done_q   <= ld_done_d;
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
      out_err_q   <= out_err_d;
      for (int b = 0; b < NBANK; b++) banks_q[b] <= banks_d[b];
    end
  end

  assign ld_done   = ld_done_q;
  assign bank_vld  = bank_vld_q;
  assign out_valid = out_valid_q;
  assign dout      = dout_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_nlu_anf_banked.sv
// Scoreboard bench for nlu_anf_banked: default instance plus an SW=3/PW=8/DW=24 instance.
// Expected results come from S-box truth tables, independent of the ANF evaluation.
module tb_nlu_anf_banked;

  logic ck = 1'b0;
  logic rst;
  always #5 ck = ~ck;

  logic        ld_valid, ld_ready, ld_bank, ld_abort, ld_done;
  logic [15:0] ld_data;
  logic [1:0]  bank_vld;
  logic        in_valid, in_ready, in_bank, out_valid, out_ready, out_err;
  logic [31:0] din, dout;

  logic        c_ld_valid, c_ld_ready, c_ld_bank, c_ld_abort, c_ld_done;
  logic [7:0]  c_ld_data;
  logic [1:0]  c_bank_vld;
  logic        c_in_valid, c_in_ready, c_in_bank, c_out_valid, c_out_ready, c_out_err;
  logic [23:0] c_din, c_dout;

  nlu_anf_banked dut (
    .ck(ck), .rst(rst), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_bank(ld_bank),
    .ld_data(ld_data), .ld_abort(ld_abort), .ld_done(ld_done), .bank_vld(bank_vld),
    .in_valid(in_valid), .in_ready(in_ready), .in_bank(in_bank), .din(din),
    .out_valid(out_valid), .out_ready(out_ready), .dout(dout), .out_err(out_err)
  );

  nlu_anf_banked #(.DW(24), .SW(3), .PW(8), .NBANK(2)) dut3 (
    .ck(ck), .rst(rst), .ld_valid(c_ld_valid), .ld_ready(c_ld_ready), .ld_bank(c_ld_bank),
    .ld_data(c_ld_data), .ld_abort(c_ld_abort), .ld_done(c_ld_done), .bank_vld(c_bank_vld),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .in_bank(c_in_bank), .din(c_din),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .dout(c_dout), .out_err(c_out_err)
  );

  typedef struct {
    logic [31:0] d;
    logic        e;
  } exp_t;

  exp_t sbq[$];
  exp_t sbq3[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   kind_q[2];

  logic [63:0] pres_t = 64'hC56B90AD3EF84712;
  logic [63:0] m_pres = 64'hE394_98F4_21BC_4A80;
  logic [63:0] m_iden = 64'h0080_0800_2000_4000;
  logic [63:0] m_comp = 64'h8080_8800_A000_C000;
  int          t3[8]  = '{3, 6, 0, 5, 7, 1, 4, 2};
  logic [23:0] m3;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // kind 0 = PRESENT, 1 = identity, 2 = complement
  function automatic logic [31:0] s4w(input int kind, input logic [31:0] d);
    logic [31:0] r;
    int          xi;
    for (int k = 0; k < 8; k++) begin
      xi = int'(d[4*k +: 4]);
      case (kind)
        0:       r[4*k +: 4] = pres_t[63-4*xi -: 4];
        1:       r[4*k +: 4] = d[4*k +: 4];
        default: r[4*k +: 4] = ~d[4*k +: 4];
      endcase
    end
    return r;
  endfunction

  function automatic logic [23:0] s3w(input logic [23:0] d);
    logic [23:0] r;
    for (int k = 0; k < 8; k++) r[3*k +: 3] = 3'(t3[int'(d[3*k +: 3])]);
    return r;
  endfunction

  task automatic load(input logic bank, input logic [63:0] m, input int kind);
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1;
      ld_bank  = bank;
      ld_data  = m[63-16*i -: 16];
      @(posedge ck); #1;
    end
    ld_valid = 1'b0;
    chk("ld_ready_commit", ld_ready, 0);
    chk("ld_done_early", ld_done, 0);
    @(posedge ck); #1;
    chk("ld_done_pulse", ld_done, 1);
    kind_q[bank] = kind;
    @(posedge ck); #1;
    chk("ld_done_clear", ld_done, 0);
  endtask

  task automatic send(input logic bank, input logic [31:0] d);
    exp_t e;
    int   n;
    e.e = (kind_q[bank] < 0);
    e.d = e.e ? 32'h0 : s4w(kind_q[bank], d);
    sbq.push_back(e);
    in_valid = 1'b1;
    in_bank  = bank;
    din      = d;
    n = 0;
    @(negedge ck);
    while (!in_ready && n < 20) begin
      @(negedge ck);
      n++;
    end
    if (!in_ready) chk("send_timeout", in_ready, 1);
    @(posedge ck); #1;
    in_valid = 1'b0;
  endtask

  always @(negedge ck) begin : mon
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (sbq.size() == 0) chk("sb_unexpected", out_valid, 0);
      else begin
        e = sbq.pop_front();
        chk("dout", dout, e.d);
        chk("out_err", out_err, e.e);
      end
    end
  end

  always @(negedge ck) begin : mon3
    exp_t e;
    if (!rst && c_out_valid && c_out_ready) begin
      if (sbq3.size() == 0) chk("sb3_unexpected", c_out_valid, 0);
      else begin
        e = sbq3.pop_front();
        chk("dout3", c_dout, e.d);
        chk("out_err3", c_out_err, e.e);
      end
    end
  end

  initial begin
    exp_t e;
    logic a;
    rst = 1'b1;
    ld_valid = 0; ld_bank = 0; ld_data = 0; ld_abort = 0;
    in_valid = 0; in_bank = 0; din = 0; out_ready = 1;
    c_ld_valid = 0; c_ld_bank = 0; c_ld_data = 0; c_ld_abort = 0;
    c_in_valid = 0; c_in_bank = 0; c_din = 0; c_out_ready = 1;
    kind_q[0] = -1; kind_q[1] = -1;
    repeat (2) @(posedge ck);
    #1;
    chk("rst_ld_ready", ld_ready, 1);
    chk("rst_ld_done", ld_done, 0);
    chk("rst_bank_vld", bank_vld, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_dout", dout, 0);
    chk("rst_out_err", out_err, 0);
    rst = 1'b0;
    @(posedge ck); #1;

    // uncommitted bank
    send(1, 32'h01234567);

    // abort after two beats
    for (int i = 0; i < 2; i++) begin
      ld_valid = 1; ld_bank = 1; ld_data = m_iden[63-16*i -: 16];
      @(posedge ck); #1;
    end
    ld_valid = 0; ld_abort = 1;
    @(posedge ck); #1;
    ld_abort = 0;
    for (int i = 0; i < 3; i++) begin
      chk("abort_ld_done", ld_done, 0);
      @(posedge ck); #1;
    end
    chk("abort_bank_vld", bank_vld, 0);
    send(1, 32'h01234567);

    // PRESENT on bank 0
    load(0, m_pres, 0);
    chk("pres_bank_vld", bank_vld, 2'b01);
    send(0, 32'h01234567);
    send(0, 32'h89ABCDEF);

    // backpressure: A stalls in the output register, B waits
    send(0, 32'h01234567);
    out_ready = 0;
    e.d = s4w(0, 32'h89ABCDEF); e.e = 0;
    sbq.push_back(e);
    in_valid = 1; in_bank = 0; din = 32'h89ABCDEF;
    for (int i = 0; i < 3; i++) begin
      @(negedge ck);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_dout", dout, s4w(0, 32'h01234567));
      @(posedge ck); #1;
    end
    out_ready = 1;
    @(negedge ck);
    @(posedge ck); #1;
    in_valid = 0;
    repeat (2) @(posedge ck);
    #1;
    chk("bp_sb_empty", sbq.size(), 0);

    // two banks
    load(1, m_iden, 1);
    load(0, m_comp, 2);
    chk("two_bank_vld", bank_vld, 2'b11);
    send(1, 32'h01234567);
    send(0, 32'h01234567);

    // hot swap on bank 0: PRESENT -> identity while streaming
    load(0, m_pres, 0);
    for (int c = 0; c < 8; c++) begin
      ld_valid = (c < 4);
      ld_bank  = 0;
      if (c < 4) ld_data = m_iden[63-16*c -: 16];
      e.d = s4w((c <= 4) ? 0 : 1, 32'h01234567); e.e = 0;
      sbq.push_back(e);
      in_valid = 1; in_bank = 0; din = 32'h01234567;
      @(posedge ck); #1;
      chk("hs_ld_done", ld_done, (c == 4));
    end
    in_valid = 0; ld_valid = 0;
    kind_q[0] = 1;
    repeat (2) @(posedge ck);
    #1;

    // reset mid-load and mid-stream
    ld_valid = 1; ld_bank = 1; ld_data = m_pres[63:48];
    @(posedge ck); #1;
    ld_data = m_pres[47:32];
    out_ready = 0;
    send(0, 32'h89ABCDEF);
    rst = 1;
    sbq.delete();
    #1;
    chk("mrst_ld_ready", ld_ready, 1);
    chk("mrst_ld_done", ld_done, 0);
    chk("mrst_bank_vld", bank_vld, 0);
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_dout", dout, 0);
    chk("mrst_out_err", out_err, 0);
    chk("mrst_bank_vld3", c_bank_vld, 0);
    ld_valid = 0; in_valid = 0; out_ready = 1;
    kind_q[0] = -1; kind_q[1] = -1;
    @(posedge ck); #1;
    rst = 0;
    @(posedge ck); #1;
    send(0, 32'h01234567);
    load(0, m_pres, 0);
    send(0, 32'h01234567);

    // SW=3, PW=8, DW=24: mask derived by Moebius transform of the truth table
    m3 = '0;
    for (int j = 0; j < 3; j++) begin
      for (int m = 0; m < 8; m++) begin
        a = 1'b0;
        for (int x = 0; x < 8; x++) begin
          if ((x & ~m) == 0) a = a ^ 1'((t3[x] >> j) & 1);
        end
        m3[j*8 + 7 - m] = a;
      end
    end
    for (int i = 0; i < 3; i++) begin
      c_ld_valid = 1; c_ld_bank = 0; c_ld_data = m3[23-8*i -: 8];
      @(posedge ck); #1;
    end
    c_ld_valid = 0;
    chk("c3_ld_done_early", c_ld_done, 0);
    @(posedge ck); #1;
    chk("c3_ld_done", c_ld_done, 1);
    chk("c3_bank_vld", c_bank_vld, 2'b01);
    @(posedge ck); #1;
    for (int i = 0; i < 3; i++) begin
      c_din = (i == 0) ? 24'h053977 : (i == 1) ? 24'hFAC688 : 24'h000000;
      e.d = {8'h00, s3w(c_din)}; e.e = 0;
      sbq3.push_back(e);
      c_in_valid = 1; c_in_bank = 0;
      @(negedge ck);
      chk("c3_in_ready", c_in_ready, 1);
      @(posedge ck); #1;
    end
    c_in_valid = 0;
    e.d = 32'h0; e.e = 1;
    sbq3.push_back(e);
    c_in_valid = 1; c_in_bank = 1; c_din = 24'h053977;
    @(posedge ck); #1;
    c_in_valid = 0;

    repeat (4) @(posedge ck);
    #1;
    chk("sb_left", sbq.size(), 0);
    chk("sb3_left", sbq3.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
